// File: rtl/eth_txrx_data_mem.sv
// eth_txrx_data_mem
//   Word-addressed Wishbone slave memory holding Ethernet TX/RX frame data,
//   with a zero-wait backdoor port for preload and inspection.
//
//   Optional feature macro: MEM_WAIT_STATE_EN
//     Defined   : WAIT state holds off ack for WAIT_CYCLES cycles.
//     Undefined : fixed one-cycle ack latency; WAIT_CYCLES is ignored.
//
//   Ports
//     clk, rst_n        system clock, async active-low reset
//     wb_*              Wishbone slave (byte address, 32-bit data, sel lanes)
//     bd_addr_i         backdoor word index
//     bd_wdata_i/be_i   backdoor write data / byte enables, bd_we_i strobe
//     bd_re_i           backdoor read strobe -> bd_rdata_o/bd_rvalid_o next cycle
//
//   state  | meaning
//   IDLE   | waiting for cyc & stb
//   WAIT   | request latched, counting wait states (MEM_WAIT_STATE_EN only)
//   RESP   | ack or err presented for one cycle
module eth_txrx_data_mem #(
   parameter int                ADDR_W      = 32,
   parameter int                MEM_WORDS   = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            wb_adr_i,
   input  logic [31:0]                  wb_dat_i,
   output logic [31:0]                  wb_dat_o,
   input  logic [3:0]                   wb_sel_i,
   input  logic                         wb_we_i,
   input  logic                         wb_cyc_i,
   input  logic                         wb_stb_i,
   output logic                         wb_ack_o,
   output logic                         wb_err_o,
   input  logic [$clog2(MEM_WORDS)-1:0] bd_addr_i,
   input  logic [31:0]                  bd_wdata_i,
   input  logic [3:0]                   bd_be_i,
   input  logic                         bd_we_i,
   input  logic                         bd_re_i,
   output logic [31:0]                  bd_rdata_o,
   output logic                         bd_rvalid_o
);

   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RESP = 2'b01;

   logic [31:0]   mem_q [MEM_WORDS];
   logic [1:0]    state_q, state_d;
   logic          ack_q, err_q, bd_rvalid_q;
   logic [31:0]   dat_q, bd_rdata_q;

   // Decode on the live bus. The extra top bit catches addresses below BASE_ADDR.
   logic [ADDR_W:0] diff;
   logic            live_inr;
   logic [AW-1:0]   live_idx;
   logic            unused_adr_lsb;

   assign diff           = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
   assign live_inr       = ~diff[ADDR_W] & (diff[ADDR_W-1:AW+2] == '0);
   assign live_idx       = diff[AW+1:2];
   assign unused_adr_lsb = ^diff[1:0];

   // Commit: the edge on which the transfer enters RESP (write + read capture).
   logic          c_en, c_we, c_inr;
   logic [AW-1:0] c_idx;
   logic [31:0]   c_dat;
   logic [3:0]    c_sel;

`ifdef MEM_WAIT_STATE_EN
   localparam logic [1:0] S_WAIT = 2'b10;
   localparam int         CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_load;
   logic             req_we_q, req_inr_q;
   logic [AW-1:0]    req_idx_q;
   logic [31:0]      req_dat_q;
   logic [3:0]       req_sel_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_load = 1'b0;
      c_en     = 1'b0;
      c_we     = wb_we_i;
      c_inr    = live_inr;
      c_idx    = live_idx;
      c_dat    = wb_dat_i;
      c_sel    = wb_sel_i;
      case (state_q)
         S_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (WAIT_CYCLES == 0) begin
                  c_en    = 1'b1;
                  state_d = S_RESP;
               end else begin
                  req_load = 1'b1;
                  cnt_d    = CNT_W'(WAIT_CYCLES - 1);
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            c_we  = req_we_q;
            c_inr = req_inr_q;
            c_idx = req_idx_q;
            c_dat = req_dat_q;
            c_sel = req_sel_q;
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               c_en    = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         req_we_q  <= 1'b0;
         req_inr_q <= 1'b0;
         req_idx_q <= '0;
         req_dat_q <= '0;
         req_sel_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (req_load) begin
            req_we_q  <= wb_we_i;
            req_inr_q <= live_inr;
            req_idx_q <= live_idx;
            req_dat_q <= wb_dat_i;
            req_sel_q <= wb_sel_i;
         end
      end
   end
`else
   localparam int unused_wait_cycles = WAIT_CYCLES;

   always_comb begin
      state_d = state_q;
      c_en    = 1'b0;
      c_we    = wb_we_i;
      c_inr   = live_inr;
      c_idx   = live_idx;
      c_dat   = wb_dat_i;
      c_sel   = wb_sel_i;
      case (state_q)
         S_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               c_en    = 1'b1;
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
         bd_rdata_q  <= '0;
         bd_rvalid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= c_en & c_inr;
         err_q   <= c_en & ~c_inr;
         if (c_en) begin
            if (!c_inr)     dat_q <= '0;
            else if (!c_we) dat_q <= mem_q[c_idx];
         end
         bd_rvalid_q <= bd_re_i;
         if (bd_re_i) bd_rdata_q <= mem_q[bd_addr_i];
      end
   end

   // Array is never reset. Backdoor write is ordered last so it wins on shared bytes.
   always_ff @(posedge clk) begin
      if (c_en && c_inr && c_we) begin
         for (int b = 0; b < 4; b++) begin
            if (c_sel[b]) mem_q[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
         end
      end
      if (bd_we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (bd_be_i[b]) mem_q[bd_addr_i][8*b +: 8] <= bd_wdata_i[8*b +: 8];
         end
      end
   end

   // Dropping cyc during RESP suppresses the handshake immediately.
   assign wb_ack_o    = ack_q & wb_cyc_i;
   assign wb_err_o    = err_q & wb_cyc_i;
   assign wb_dat_o    = dat_q;
   assign bd_rdata_o  = bd_rdata_q;
   assign bd_rvalid_o = bd_rvalid_q;

endmodule

// File: tb/tb_eth_txrx_data_mem.sv
module tb_eth_txrx_data_mem;

   localparam int          MW   = 1024;
   localparam int          WC   = 2;
   localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef MEM_WAIT_STATE_EN
   localparam int LAT = 1 + WC;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
   logic [9:0]  bd_addr;
   logic [31:0] bd_wdata, bd_rdata;
   logic [3:0]  bd_be;
   logic        bd_we, bd_re, bd_rvalid;

   eth_txrx_data_mem #(
      .ADDR_W(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
      .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
      .wb_ack_o(wb_ack), .wb_err_o(wb_err),
      .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata), .bd_be_i(bd_be),
      .bd_we_i(bd_we), .bd_re_i(bd_re),
      .bd_rdata_o(bd_rdata), .bd_rvalid_o(bd_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic        chk_data;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     wb_q[$];
   logic [31:0] bd_q[$];
   logic [31:0] ref_mem [MW];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          resp_seen = 0;
   int          cyc_cnt  = 0;

   always @(posedge clk) cyc_cnt++;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] en);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic bit in_rng(logic [31:0] a);
      longint la = longint'(a);
      return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * MW);
   endfunction

   // Scoreboard monitor: pops one expectation per observed response.
   always @(negedge clk) begin
      wb_exp_t e;
      logic [31:0] bexp;
      if (wb_ack || wb_err) begin
         resp_seen++;
         if (wb_q.size() == 0) begin
            chk("wb_unexpected_resp", {30'b0, wb_ack, wb_err}, 32'h0);
         end else begin
            e = wb_q.pop_front();
            chk("wb_resp_kind", {30'b0, wb_ack, wb_err}, {30'b0, ~e.err, e.err});
            if (e.chk_data) chk("wb_rdata", wb_dat_r, e.data);
         end
      end
      if (bd_rvalid) begin
         if (bd_q.size() == 0) begin
            chk("bd_unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            bexp = bd_q.pop_front();
            chk("bd_rdata", bd_rdata, bexp);
         end
      end
   end

   task automatic bd_write(input int idx, input logic [31:0] d, input logic [3:0] be);
      ref_mem[idx] = merge(ref_mem[idx], d, be);
      @(posedge clk); #1;
      bd_addr = 10'(idx); bd_wdata = d; bd_be = be; bd_we = 1'b1;
      @(posedge clk); #1;
      bd_we = 1'b0; bd_be = 4'h0;
   endtask

   task automatic bd_read(input int idx);
      bd_q.push_back(ref_mem[idx]);
      @(posedge clk); #1;
      bd_addr = 10'(idx); bd_re = 1'b1;
      @(posedge clk); #1;
      bd_re = 1'b0;
   endtask

   task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] sel);
      wb_exp_t e;
      int      lat;
      int      idx;
      bit      inr = in_rng(a);
      idx = inr ? int'((a - BASE) >> 2) : 0;
      e.err      = ~inr;
      e.chk_data = ~inr | ~we;
      e.data     = (inr && !we) ? ref_mem[idx] : 32'h0;
      wb_q.push_back(e);
      if (inr && we) ref_mem[idx] = merge(ref_mem[idx], d, sel);
      @(posedge clk); #1;
      wb_adr = a; wb_we = we; wb_dat_w = d; wb_sel = sel; wb_cyc = 1'b1; wb_stb = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!(wb_ack || wb_err) && lat < 20);
      chk("wb_latency", 32'(lat), 32'(LAT));
      @(negedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   // Wishbone transfer and backdoor write hitting the word on the same commit edge.
   task automatic wb_bd_same_edge(input int idx, input logic we, input logic [31:0] wd,
                                  input logic [3:0] sel, input logic [31:0] bdd,
                                  input logic [3:0] be);
      wb_exp_t e;
      e.err = 1'b0; e.chk_data = ~we; e.data = ref_mem[idx];
      wb_q.push_back(e);
      if (we) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
      ref_mem[idx] = merge(ref_mem[idx], bdd, be);
      @(posedge clk); #1;
      wb_adr = BASE + 32'(4 * idx); wb_we = we; wb_dat_w = wd; wb_sel = sel;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      bd_addr = 10'(idx); bd_wdata = bdd; bd_be = be; bd_we = 1'b1;
      @(posedge clk); #1;
      bd_we = 1'b0; bd_be = 4'h0;
      chk("same_edge_ack", {31'b0, wb_ack}, 32'd1);
      @(negedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   // cyc dropped one cycle after the request is sampled.
   task automatic wb_abort(input int idx, input logic we, input logic [31:0] d);
      int seen0 = resp_seen;
      if (we && LAT == 1) ref_mem[idx] = d;
      @(posedge clk); #1;
      wb_adr = BASE + 32'(4 * idx); wb_we = we; wb_dat_w = d; wb_sel = 4'hF;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      #1;
      chk("abort_ack_low", {30'b0, wb_ack, wb_err}, 32'd0);
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("abort_no_resp", 32'(resp_seen - seen0), 32'd0);
   endtask

   task automatic wb_burst_read(input int idx0, input int n);
      wb_exp_t e;
      int k, guard, last;
      for (int i = 0; i < n; i++) begin
         e.err = 1'b0; e.chk_data = 1'b1; e.data = ref_mem[idx0 + i];
         wb_q.push_back(e);
      end
      @(posedge clk); #1;
      wb_adr = BASE + 32'(4 * idx0); wb_we = 1'b0; wb_sel = 4'hF;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      k = 0; guard = 0; last = 0;
      while (k < n && guard < 100) begin
         @(posedge clk); #1;
         guard++;
         if (wb_ack) begin
            if (k > 0) chk("burst_spacing", 32'(cyc_cnt - last), 32'(LAT + 1));
            last = cyc_cnt;
            k++;
            if (k < n) wb_adr = BASE + 32'(4 * (idx0 + k));
         end
      end
      chk("burst_count", 32'(k), 32'(n));
      @(negedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
   endtask

   function automatic logic [31:0] oor_addr();
      case ($urandom_range(0, 2))
         0:       return BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 1023));
         1:       return BASE - 32'd4 - 32'(4 * $urandom_range(0, 1023));
         default: return 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int lat;
      rst_n = 1'b0;
      wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
      bd_addr = '0; bd_wdata = '0; bd_be = '0; bd_we = 0; bd_re = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack_err_rvalid", {29'b0, wb_ack, wb_err, bd_rvalid}, 32'd0);
      chk("rst_wb_dat", wb_dat_r, 32'h0);
      chk("rst_bd_rdata", bd_rdata, 32'h0);
      rst_n = 1'b1;

      // Preload every word so the model is fully known.
      @(posedge clk); #1;
      bd_we = 1'b1; bd_be = 4'hF;
      for (int i = 0; i < MW; i++) begin
         ref_mem[i] = $urandom;
         bd_addr = 10'(i); bd_wdata = ref_mem[i];
         @(posedge clk); #1;
      end
      bd_we = 1'b0; bd_be = 4'h0;

      bd_write(5, 32'hDEADBEEF, 4'hF);
      wb_xfer(BASE + 32'h14, 1'b0, 32'h0, 4'hF);

      bd_write(7, 32'hAABBCCDD, 4'hF);
      wb_xfer(BASE + 32'h1C, 1'b1, 32'h1122_3344, 4'b0101);
      bd_read(7);

      wb_xfer(BASE + 32'h18, 1'b1, 32'hCAFE_F00D, 4'b0000);
      bd_read(6);

      wb_xfer(BASE + 32'(4 * MW), 1'b1, 32'h5555_AAAA, 4'hF);
      wb_xfer(BASE + 32'(4 * MW), 1'b0, 32'h0, 4'hF);
      wb_xfer(BASE - 32'd4, 1'b1, 32'h6666_9999, 4'hF);
      bd_read(0);
      bd_read(MW - 1);

      wb_bd_same_edge(9, 1'b1, 32'h0000_FFFF, 4'hF, 32'h1234_5678, 4'b0011);
      bd_read(9);
      wb_bd_same_edge(10, 1'b0, 32'h0, 4'hF, 32'h0BAD_CAFE, 4'hF);
      bd_read(10);

      wb_burst_read(20, 4);

      wb_abort(11, 1'b1, 32'h7777_1234);
      bd_read(11);
      wb_abort(12, 1'b0, 32'h0);

      // Reset while ack and rvalid are both high.
      @(posedge clk); #1;
      wb_adr = BASE + 32'h0C; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
      lat = 0;
      do begin
         if (lat == LAT - 1) begin bd_addr = 10'd3; bd_re = 1'b1; end
         @(posedge clk); #1;
         bd_re = 1'b0;
         lat++;
      end while (!wb_ack && lat < 20);
      chk("pre_reset_ack_rvalid", {30'b0, wb_ack, bd_rvalid}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_ack_err_rvalid", {29'b0, wb_ack, wb_err, bd_rvalid}, 32'd0);
      chk("mid_reset_wb_dat", wb_dat_r, 32'h0);
      chk("mid_reset_bd_rdata", bd_rdata, 32'h0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bd_read(3);
      wb_xfer(BASE + 32'h0C, 1'b0, 32'h0, 4'hF);

      for (int it = 0; it < 150; it++) begin
         int idx = $urandom_range(0, MW - 1);
         case ($urandom_range(0, 5))
            0: bd_write(idx, $urandom, 4'($urandom_range(0, 15)));
            1: bd_read(idx);
            2: wb_xfer(BASE + 32'(4 * idx), 1'b0, 32'h0, 4'($urandom_range(0, 15)));
            3: wb_xfer(BASE + 32'(4 * idx), 1'b1, $urandom, 4'($urandom_range(0, 15)));
            4: wb_xfer(oor_addr(), 1'($urandom_range(0, 1)), $urandom, 4'hF);
            default: wb_xfer(BASE + 32'(4 * idx) + 32'($urandom_range(0, 3)), 1'b0,
                             32'h0, 4'hF);
         endcase
      end

      repeat (4) @(posedge clk);
      #1;
      chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
      chk("bd_queue_drained", 32'(bd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
